// File: rtl/fwd_pkg.sv
// Shared definitions for the MEM-stage forwarding history block.
package fwd_pkg;

    // Lookup port roles.
    localparam int PORT_ADDR  = 0;
    localparam int PORT_WDATA = 1;

    // Field widths of a history record in the default configuration.
    localparam int REC_REG_AW = 3;
    localparam int REC_DATA_W = 16;

    // One write-back record: up to two register writes (second one used by SWAP).
    // The top module stores the same fields in arrays sized by its own parameters.
    typedef struct packed {
        logic                  v1;
        logic [REC_REG_AW-1:0] r1;
        logic [REC_DATA_W-1:0] d1;
        logic                  v2;
        logic [REC_REG_AW-1:0] r2;
        logic [REC_DATA_W-1:0] d2;
    } fwd_rec_t;

    // Width of a per-port age code: 0 = live WB, 1..depth = history record.
    function automatic int age_w(input int depth);
        return $clog2(depth + 2);
    endfunction

    // Width of the occupancy counter: 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_lookup.sv
// Per-port youngest-wins match of one source register against live WB and history.
module fwd_lookup
    import fwd_pkg::*;
#(
    parameter  int REG_AW = 3,
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 2,
    localparam int AGE_W  = age_w(DEPTH)
) (
    input  logic [REG_AW-1:0]       src_reg,
    input  logic                    wb_we1,
    input  logic [REG_AW-1:0]       wb_rdst1,
    input  logic [DATA_W-1:0]       wb_data1,
    input  logic                    wb_we2,
    input  logic [REG_AW-1:0]       wb_rdst2,
    input  logic [DATA_W-1:0]       wb_data2,
    input  logic [DEPTH-1:0]        h_v1,
    input  logic [DEPTH*REG_AW-1:0] h_r1,
    input  logic [DEPTH*DATA_W-1:0] h_d1,
    input  logic [DEPTH-1:0]        h_v2,
    input  logic [DEPTH*REG_AW-1:0] h_r2,
    input  logic [DEPTH*DATA_W-1:0] h_d2,
    output logic                    hit,
    output logic [DATA_W-1:0]       data,
    output logic [AGE_W-1:0]        age
);

    // Scan oldest to youngest so later (younger) matches overwrite earlier ones;
    // within a record write 2 is checked after write 1 so it wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        age  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (h_v1[k] && (h_r1[k*REG_AW +: REG_AW] == src_reg)) begin
                hit  = 1'b1;
                data = h_d1[k*DATA_W +: DATA_W];
                age  = AGE_W'(k + 1);
            end
            if (h_v2[k] && (h_r2[k*REG_AW +: REG_AW] == src_reg)) begin
                hit  = 1'b1;
                data = h_d2[k*DATA_W +: DATA_W];
                age  = AGE_W'(k + 1);
            end
        end
        if (wb_we1 && (wb_rdst1 == src_reg)) begin
            hit  = 1'b1;
            data = wb_data1;
            age  = '0;
        end
        if (wb_we2 && (wb_rdst2 == src_reg)) begin
            hit  = 1'b1;
            data = wb_data2;
            age  = '0;
        end
    end

endmodule

// File: rtl/mem_fwd_history.sv
// MEM-stage forwarding with a DEPTH-record write-back history and occupancy count.
module mem_fwd_history
    import fwd_pkg::*;
#(
    parameter  int REG_AW    = 3,
    parameter  int DATA_W    = 16,
    parameter  int DEPTH     = 2,
    parameter  int NUM_PORTS = 2,
    localparam int AGE_W     = age_w(DEPTH),
    localparam int OCC_W     = occ_w(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        advance_in,
    input  logic                        flush_in,
    input  logic                        wb_we1_in,
    input  logic [REG_AW-1:0]           wb_rdst1_in,
    input  logic [DATA_W-1:0]           wb_data1_in,
    input  logic                        wb_we2_in,
    input  logic [REG_AW-1:0]           wb_rdst2_in,
    input  logic [DATA_W-1:0]           wb_data2_in,
    input  logic [NUM_PORTS*REG_AW-1:0] src_reg_in,
    output logic [NUM_PORTS-1:0]        fwd_hit_out,
    output logic [NUM_PORTS*DATA_W-1:0] fwd_data_out,
    output logic [NUM_PORTS*AGE_W-1:0]  fwd_age_out,
    output logic [OCC_W-1:0]            occ_out
);

    // History storage; slot k-1 holds record k (slot 0 = youngest).
    logic [DEPTH-1:0]        h_v1, h_v2;
    logic [DEPTH*REG_AW-1:0] h_r1, h_r2;
    logic [DEPTH*DATA_W-1:0] h_d1, h_d2;
    logic [OCC_W-1:0]        occ_q;
    logic [OCC_W-1:0]        occ_next;
    logic [OCC_W:0]          occ_ext;

    // Occupancy after an advance: +1 for a non-empty incoming record, -1 for a
    // non-empty record falling off the end, clamped to DEPTH.
    always_comb begin
        occ_ext = {1'b0, occ_q} + (OCC_W + 1)'(wb_we1_in | wb_we2_in);
        if ((h_v1[DEPTH-1] | h_v2[DEPTH-1]) && (occ_ext != '0)) begin
            occ_ext = occ_ext - 1'b1;
        end
        if (occ_ext > (OCC_W + 1)'(DEPTH)) begin
            occ_ext = (OCC_W + 1)'(DEPTH);
        end
        occ_next = occ_ext[OCC_W-1:0];
    end

    // History shift register and occupancy counter: reset, flush, capture or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_v1  <= '0;
            h_v2  <= '0;
            h_r1  <= '0;
            h_r2  <= '0;
            h_d1  <= '0;
            h_d2  <= '0;
            occ_q <= '0;
        end else if (flush_in) begin
            h_v1  <= '0;
            h_v2  <= '0;
            occ_q <= '0;
        end else if (advance_in) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                h_v1[k]                 <= h_v1[k-1];
                h_v2[k]                 <= h_v2[k-1];
                h_r1[k*REG_AW +: REG_AW] <= h_r1[(k-1)*REG_AW +: REG_AW];
                h_r2[k*REG_AW +: REG_AW] <= h_r2[(k-1)*REG_AW +: REG_AW];
                h_d1[k*DATA_W +: DATA_W] <= h_d1[(k-1)*DATA_W +: DATA_W];
                h_d2[k*DATA_W +: DATA_W] <= h_d2[(k-1)*DATA_W +: DATA_W];
            end
            h_v1[0]           <= wb_we1_in;
            h_v2[0]           <= wb_we2_in;
            h_r1[REG_AW-1:0]  <= wb_rdst1_in;
            h_r2[REG_AW-1:0]  <= wb_rdst2_in;
            h_d1[DATA_W-1:0]  <= wb_data1_in;
            h_d2[DATA_W-1:0]  <= wb_data2_in;
            occ_q             <= occ_next;
        end
    end

    assign occ_out = occ_q;

    // One independent lookup per source-operand port.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        fwd_lookup #(
            .REG_AW (REG_AW),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_lookup (
            .src_reg  (src_reg_in[p*REG_AW +: REG_AW]),
            .wb_we1   (wb_we1_in),
            .wb_rdst1 (wb_rdst1_in),
            .wb_data1 (wb_data1_in),
            .wb_we2   (wb_we2_in),
            .wb_rdst2 (wb_rdst2_in),
            .wb_data2 (wb_data2_in),
            .h_v1     (h_v1),
            .h_r1     (h_r1),
            .h_d1     (h_d1),
            .h_v2     (h_v2),
            .h_r2     (h_r2),
            .h_d2     (h_d2),
            .hit      (fwd_hit_out[p]),
            .data     (fwd_data_out[p*DATA_W +: DATA_W]),
            .age      (fwd_age_out[p*AGE_W +: AGE_W])
        );
    end

endmodule

// File: tb/tb_mem_fwd_history.sv
// Directed scoreboard bench: default configuration plus a DEPTH=4/3-port/32-bit instance.
module tb_mem_fwd_history;
    import fwd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- default instance ----------------
    logic        m_adv, m_flush, m_we1, m_we2;
    logic [2:0]  m_r1, m_r2;
    logic [15:0] m_d1, m_d2;
    logic [5:0]  m_src;
    logic [1:0]  m_hit;
    logic [31:0] m_data;
    logic [3:0]  m_age;
    logic [1:0]  m_occ;

    mem_fwd_history u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance_in   (m_adv),
        .flush_in     (m_flush),
        .wb_we1_in    (m_we1),
        .wb_rdst1_in  (m_r1),
        .wb_data1_in  (m_d1),
        .wb_we2_in    (m_we2),
        .wb_rdst2_in  (m_r2),
        .wb_data2_in  (m_d2),
        .src_reg_in   (m_src),
        .fwd_hit_out  (m_hit),
        .fwd_data_out (m_data),
        .fwd_age_out  (m_age),
        .occ_out      (m_occ)
    );

    // ---------------- sweep instance ----------------
    logic        s_adv, s_we1;
    logic [2:0]  s_r1;
    logic [31:0] s_d1;
    logic [8:0]  s_src;
    logic [2:0]  s_hit;
    logic [95:0] s_data;
    logic [8:0]  s_age;
    logic [2:0]  s_occ;

    mem_fwd_history #(
        .REG_AW    (3),
        .DATA_W    (32),
        .DEPTH     (4),
        .NUM_PORTS (3)
    ) u_sw (
        .clk          (clk),
        .rst_n        (rst_n),
        .advance_in   (s_adv),
        .flush_in     (1'b0),
        .wb_we1_in    (s_we1),
        .wb_rdst1_in  (s_r1),
        .wb_data1_in  (s_d1),
        .wb_we2_in    (1'b0),
        .wb_rdst2_in  (3'd0),
        .wb_data2_in  (32'd0),
        .src_reg_in   (s_src),
        .fwd_hit_out  (s_hit),
        .fwd_data_out (s_data),
        .fwd_age_out  (s_age),
        .occ_out      (s_occ)
    );

    // ---------------- scoreboard ----------------
    // main entry: {hit[1:0], data1, data0, age1, age0, occ}
    logic [39:0]  exp_q[$];
    string        tag_q[$];
    // sweep entry: {hit[2:0], data2, data1, data0, age2, age1, age0, occ}
    logic [110:0] sw_q[$];
    string        sw_tag_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    logic drain_to = 1'b0;
    logic drain_seen = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        logic [39:0]  e;
        logic [110:0] s;
        string        t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk({t, " hit"},  128'(m_hit),  128'(e[39:38]));
            chk({t, " data"}, 128'(m_data), 128'(e[37:6]));
            chk({t, " age"},  128'(m_age),  128'(e[5:2]));
            chk({t, " occ"},  128'(m_occ),  128'(e[1:0]));
        end
        if (sw_q.size() > 0) begin
            s = sw_q.pop_front();
            t = sw_tag_q.pop_front();
            chk({t, " hit"},  128'(s_hit),  128'(s[110:108]));
            chk({t, " data"}, 128'(s_data), 128'(s[107:12]));
            chk({t, " age"},  128'(s_age),  128'(s[11:3]));
            chk({t, " occ"},  128'(s_occ),  128'(s[2:0]));
        end
        if (drain_to && !drain_seen) begin
            drain_seen = 1'b1;
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d main / %0d sweep entries left, expected 0", exp_q.size(), sw_q.size());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_drv(input logic adv, input logic fl,
                         input logic we1, input logic [2:0] r1, input logic [15:0] d1,
                         input logic we2, input logic [2:0] r2, input logic [15:0] d2,
                         input logic [2:0] s0, input logic [2:0] s1);
        m_adv   = adv;
        m_flush = fl;
        m_we1   = we1;
        m_r1    = r1;
        m_d1    = d1;
        m_we2   = we2;
        m_r2    = r2;
        m_d2    = d2;
        m_src[PORT_ADDR*3 +: 3]  = s0;
        m_src[PORT_WDATA*3 +: 3] = s1;
    endtask

    task automatic exp_m(input string t, input logic [1:0] hit,
                         input logic [15:0] dp1, input logic [15:0] dp0,
                         input logic [1:0] ap1, input logic [1:0] ap0, input logic [1:0] occ);
        exp_q.push_back({hit, dp1, dp0, ap1, ap0, occ});
        tag_q.push_back(t);
    endtask

    task automatic s_drv(input logic adv, input logic we1, input logic [2:0] r1, input logic [31:0] d1);
        s_adv = adv;
        s_we1 = we1;
        s_r1  = r1;
        s_d1  = d1;
    endtask

    task automatic exp_s(input string t, input logic [2:0] hit,
                         input logic [31:0] dp2, input logic [31:0] dp1, input logic [31:0] dp0,
                         input logic [2:0] ap2, input logic [2:0] ap1, input logic [2:0] ap0,
                         input logic [2:0] occ);
        sw_q.push_back({hit, dp2, dp1, dp0, ap2, ap1, ap0, occ});
        sw_tag_q.push_back(t);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        m_src = '0;
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_drv(0, 0, 0, 0);
        s_src = {3'd7, 3'd4, 3'd1};
        tick();
        exp_m("reset", 2'b00, 0, 0, 0, 0, 0);
        exp_s("sw_reset", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;

        // live WB hit, then capture
        m_drv(1, 0, 1, 3, 16'h00AA, 0, 0, 0, 3, 0);
        exp_m("wb_live", 2'b01, 0, 16'h00AA, 0, 0, 0);
        tick();
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
        exp_m("cap_r3", 2'b01, 0, 16'h00AA, 0, 1, 1);
        tick();

        // history ageing and drop-off
        m_drv(1, 0, 1, 5, 16'h1234, 0, 0, 0, 3, 5);
        exp_m("live_r5", 2'b11, 16'h1234, 16'h00AA, 0, 1, 1);
        tick();
        m_drv(1, 0, 0, 0, 0, 0, 0, 0, 3, 5);
        exp_m("age1_age2", 2'b11, 16'h1234, 16'h00AA, 1, 2, 2);
        tick();
        m_drv(1, 0, 0, 0, 0, 0, 0, 0, 3, 5);
        exp_m("age2", 2'b10, 16'h1234, 0, 2, 0, 1);
        tick();
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 3, 5);
        exp_m("aged_out", 2'b00, 0, 0, 0, 0, 0);
        tick();

        // priority: live over history, write 2 over write 1
        m_drv(1, 0, 1, 2, 16'h0011, 0, 0, 0, 2, 2);
        exp_m("p_live", 2'b11, 16'h0011, 16'h0011, 0, 0, 0);
        tick();
        m_drv(0, 0, 1, 2, 16'h0022, 0, 0, 0, 2, 2);
        exp_m("p_wb_over_hist", 2'b11, 16'h0022, 16'h0022, 0, 0, 1);
        tick();
        m_drv(1, 0, 1, 4, 16'h0001, 1, 4, 16'h0002, 4, 4);
        exp_m("p_swap_live", 2'b11, 16'h0002, 16'h0002, 0, 0, 1);
        tick();

        // hold for three cycles
        for (int i = 0; i < 3; i++) begin
            m_drv(0, 0, 0, 0, 0, 0, 0, 0, 4, 2);
            exp_m("hold", 2'b11, 16'h0011, 16'h0002, 2, 1, 2);
            tick();
        end

        // flush with advance: live lookup still works, nothing captured
        m_drv(1, 1, 1, 6, 16'h0066, 0, 0, 0, 6, 4);
        exp_m("flush_cyc", 2'b11, 16'h0002, 16'h0066, 1, 0, 2);
        tick();
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 6, 4);
        exp_m("post_flush", 2'b00, 0, 0, 0, 0, 0);
        tick();

        // fill, saturate, then reset mid-operation
        m_drv(1, 0, 1, 1, 16'h0101, 0, 0, 0, 1, 1);
        exp_m("fill1", 2'b11, 16'h0101, 16'h0101, 0, 0, 0);
        tick();
        m_drv(1, 0, 1, 7, 16'h0707, 0, 0, 0, 1, 7);
        exp_m("fill2", 2'b11, 16'h0707, 16'h0101, 0, 1, 1);
        tick();
        m_drv(1, 0, 1, 5, 16'h0555, 0, 0, 0, 1, 7);
        exp_m("full_adv", 2'b11, 16'h0707, 16'h0101, 1, 2, 2);
        tick();
        rst_n = 1'b0;
        m_drv(1, 0, 1, 3, 16'h0333, 0, 0, 0, 5, 7);
        exp_m("sat_keep", 2'b11, 16'h0707, 16'h0555, 2, 1, 2);
        tick();
        rst_n = 1'b1;
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 5, 7);
        exp_m("mid_reset", 2'b00, 0, 0, 0, 0, 0);
        tick();

        // register 0 forwards like any other
        m_drv(1, 0, 0, 0, 0, 1, 0, 16'h0F0F, 0, 0);
        exp_m("r0_live", 2'b11, 16'h0F0F, 16'h0F0F, 0, 0, 0);
        tick();
        m_drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_m("r0_hist", 2'b11, 16'h0F0F, 16'h0F0F, 1, 1, 1);
        tick();

        // sweep instance: R1..R4 = 0xDEAD000k, lookups R1 / R4 / R7
        for (int k = 1; k <= 4; k++) begin
            s_drv(1, 1, 3'(k), 32'hDEAD0000 | 32'(k));
            if (k == 4) begin
                exp_s("sw_k4", 3'b011, 0, 32'hDEAD0004, 32'hDEAD0001, 0, 0, 3, 3);
            end
            tick();
        end
        s_drv(0, 0, 0, 0);
        exp_s("sw_full", 3'b011, 0, 32'hDEAD0004, 32'hDEAD0001, 0, 1, 4, 4);
        tick();
        s_drv(1, 0, 0, 0);
        tick();
        s_drv(0, 0, 0, 0);
        exp_s("sw_drop", 3'b010, 0, 32'hDEAD0004, 0, 0, 2, 0, 3);
        tick();

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0 && sw_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || sw_q.size() != 0) begin
            drain_to = 1'b1;
            @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_fwd_history.md
# mem_fwd_history

Parametrised successor to the MEM-stage forwarding unit: it keeps a short history of the last DEPTH write-back records, each up to two register writes (Rdst1/Rdst2, as for SWAP). Any of NUM_PORTS source operands is resolved against the live write-back stage and that history, with youngest-wins priority. It sits beside the MEM stage and feeds forwarded data directly to the memory address and write-data muxes. It adds capture, hold, flush and occupancy tracking to the single-cycle compare-only unit it replaces.

## Interface
- REG_AW, 3: register-number width.
- DATA_W, 16: data width.
- DEPTH, 2: number of history records (DEPTH ≥ 1).
- NUM_PORTS, 2: number of source-operand lookup ports (port 0 = memory address, port 1 = memory write data).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- advance_in  in  1  pipeline advances this cycle; history captures the current WB record.
- flush_in  in  1  invalidates all history records.
- wb_we1_in  in  1  WB stage writes wb_rdst1_in.
- wb_rdst1_in  in  REG_AW  first destination register in WB.
- wb_data1_in  in  DATA_W  data for wb_rdst1_in.
- wb_we2_in  in  1  WB stage writes wb_rdst2_in.
- wb_rdst2_in  in  REG_AW  second destination register in WB.
- wb_data2_in  in  DATA_W  data for wb_rdst2_in.
- src_reg_in  in  NUM_PORTS*REG_AW  packed source register numbers; port p occupies bits [p*REG_AW +: REG_AW].
- fwd_hit_out  out  NUM_PORTS  port p has a forwarded value.
- fwd_data_out  out  NUM_PORTS*DATA_W  packed forwarded data, valid when the matching hit bit is 1, otherwise 0.
- fwd_age_out  out  NUM_PORTS*2... no: NUM_PORTS*$clog2(DEPTH+2)  source of the hit per port: 0 = live WB, k = history record k (1 = youngest); 0 when no hit.
- occ_out  out  $clog2(DEPTH+1)  number of history records holding at least one valid write.

## Operation
- Each history record holds {v1, r1, d1, v2, r2, d2}. Record 1 is the youngest and record DEPTH the oldest.
- Capture: when advance_in=1 and flush_in=0, records shift (k → k+1, record DEPTH is discarded). Record 1 then loads {wb_we1_in, wb_rdst1_in, wb_data1_in, wb_we2_in, wb_rdst2_in, wb_data2_in}. A record with both we bits 0 is still shifted in, as an empty bubble.
- Hold: when advance_in=0 and flush_in=0, the history is unchanged.
- Flush: when flush_in=1, all v1/v2 are cleared next cycle, regardless of advance_in. The current WB record is not captured. The live WB lookup in the flush cycle is still performed.
- Lookup for each port runs independently and combinationally. Priority order is:
  - live WB write 2, then
  - live WB write 1, then
  - record 1 write 2, then record 1 write 1, and so on down to record DEPTH write 1.
  The first valid entry whose register number equals src_reg_in wins. Write 2 outranks write 1 within one record, matching register-file commit order for Rdst1==Rdst2.
- No match: hit=0, data=0, age=0.
- occ_out counts records with (v1|v2).
  - It is a registered counter, updated with the same shift.
  - On advance it is adjusted by +1 if the incoming record is non-empty and −1 if the discarded record DEPTH was non-empty.
  - It saturates at DEPTH and goes to 0 on flush.

## Timing
- Lookup latency is 0 cycles (combinational from inputs and current state). Capture latency is 1 cycle: a value written in WB at cycle n is visible as record 1 from cycle n+1 when advance_in=1 at n.
- Reset: all v bits 0, all r/d 0, occ_out=0, and therefore fwd_hit_out=0, fwd_data_out=0, fwd_age_out=0 (the lookup outputs reach these values only when the WB write-enables are also 0).
- rst_n=0 overrides flush_in and advance_in. Reset asserted mid-operation discards all history at the next edge.
- At full occupancy, an advance with a non-empty incoming record and a non-empty record DEPTH keeps occ_out=DEPTH.
- Register 0 is not special: every register number is forwardable.

## Structure
- Shared package fwd_pkg holds:
  - the history-record struct and its field widths;
  - the AGE_W = $clog2(DEPTH+2) helper;
  - localparams for port indices (PORT_ADDR=0, PORT_WDATA=1).
- One sub-module: fwd_lookup. It does a per-port priority match over {live WB, history} and is instantiated NUM_PORTS times via generate. The history shift register and occupancy counter stay in the top module.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then WB writes R3=0x00AA with src_reg_in port0=3 → same cycle hit0=1, data0=0x00AA, age0=0; occ_out=0 until the next edge, then 1.
- History hit: capture R5=0x1234 with advance, next cycle WB idle, port1=5 → hit1=1, data1=0x1234, age1=1. After a second advance of an empty record → age1=2. After a third → hit1=0 (DEPTH=2), occ_out=0.
- Priority: record 1 has R2=0x0011, live WB writes R2=0x0022, port0=2 → data0=0x0022, age0=0. With SWAP wb_rdst1=wb_rdst2=4, data1=0x0001, data2=0x0002 → data=0x0002.
- Hold vs flush: fill 2 records, advance_in=0 for 3 cycles → lookups and occ_out=2 unchanged. Then flush_in=1 with advance_in=1 and a WB write to R6 → next cycle occ_out=0 and no hit on R6.
- Reset mid-operation: occ_out=2, drive rst_n=0 for one cycle while advance_in=1 → next cycle occ_out=0, all history hits 0.
- Parameter sweep: DEPTH=4, NUM_PORTS=3, DATA_W=32. Four distinct writes R1..R4 = 0xDEAD000k, then lookup R1/R4/R7 → ages 4/1/0-with-hit=0, data 0xDEAD0001/0xDEAD0004/0.
